// File: rtl/dice_race_pkg.sv
// Shared types and constants for the dice race game FSM.
// Dice colour codes map one-to-one onto step counts; NONE means no move.
package dice_race_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_ROLL  = 3'd1,
        ST_MOVE       = 3'd2,
        ST_WAIT_CLEAR = 3'd3,
        ST_WIN        = 3'd4
    } state_e;

    typedef logic [1:0] player_t;
    typedef logic [1:0] steps_t;

    localparam logic [1:0] COLOR_NONE  = 2'd0;
    localparam logic [1:0] COLOR_RED   = 2'd1;
    localparam logic [1:0] COLOR_GREEN = 2'd2;
    localparam logic [1:0] COLOR_BLUE  = 2'd3;

    localparam steps_t STEPS_RED   = 2'd1;
    localparam steps_t STEPS_GREEN = 2'd2;
    localparam steps_t STEPS_BLUE  = 2'd3;

    function automatic steps_t color_steps(input logic [1:0] color);
        steps_t s;
        case (color)
            COLOR_RED:   s = STEPS_RED;
            COLOR_GREEN: s = STEPS_GREEN;
            COLOR_BLUE:  s = STEPS_BLUE;
            default:     s = 2'd0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/race_step_timer.sv
// Animation pace timer: counts 0..STEP_CYCLES-1 while enabled, wraps to 0.
// Latency: tick is combinational on the terminal-count cycle; clear wins over enable, no backpressure.
module race_step_timer #(
    parameter int STEP_CYCLES = 25000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    assign tick = enable && !clear && (cnt_q == TERM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= (cnt_q == TERM) ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/dice_race_turn_fsm.sv
// Turn FSM: latches a dice roll, advances the current token one square per step period, rotates turns.
// Latency: first square STEP_CYCLES cycles after roll accept; inputs are pulses, never stalled.
module dice_race_turn_fsm
    import dice_race_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int BOARD_LEN   = 20,
    parameter int POS_W       = 5,
    parameter int STEP_CYCLES = 25000000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         new_game,
    input  logic                         result_ready,
    input  logic [1:0]                   movement_steps,
    input  logic                         turn_end,
    output logic [1:0]                   cur_player,
    output logic [NUM_PLAYERS*POS_W-1:0] player_pos,
    output logic [1:0]                   steps_left,
    output logic                         moving,
    output logic                         game_over,
    output logic [1:0]                   winner,
    output logic [2:0]                   fsm_state
);

    localparam logic [POS_W-1:0] FINISH      = POS_W'(BOARD_LEN - 1);
    localparam player_t          LAST_PLAYER = player_t'(NUM_PLAYERS - 1);

    state_e                               state_q, state_nxt;
    player_t                              cur_q, cur_nxt;
    player_t                              win_q, win_nxt;
    logic [NUM_PLAYERS-1:0][POS_W-1:0]    pos_q, pos_nxt;
    steps_t                               steps_q, steps_nxt;
    logic                                 go_q, go_nxt;
    logic                                 pend_q, pend_nxt;
    logic                                 timer_clr, timer_en, step_tick;
    logic [POS_W-1:0]                     cur_pos, pos_inc;
    player_t                              next_player;
    steps_t                               roll_steps;

    race_step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clr),
        .enable (timer_en),
        .tick   (step_tick)
    );

    always_comb begin
        cur_pos = '0;
        for (int k = 0; k < NUM_PLAYERS; k++) begin
            if (player_t'(k) == cur_q) cur_pos = pos_q[k];
        end
    end

    assign pos_inc     = cur_pos + POS_W'(1);
    assign next_player = (cur_q == LAST_PLAYER) ? '0 : cur_q + player_t'(1);
    assign roll_steps  = color_steps(movement_steps);
    assign timer_en    = (state_q == ST_MOVE);

    always_comb begin
        state_nxt = state_q;
        cur_nxt   = cur_q;
        pos_nxt   = pos_q;
        steps_nxt = steps_q;
        go_nxt    = go_q;
        win_nxt   = win_q;
        pend_nxt  = pend_q;
        timer_clr = 1'b0;

        case (state_q)
            ST_IDLE: ;
            ST_WAIT_ROLL: begin
                if (result_ready && roll_steps != 2'd0) begin
                    steps_nxt = roll_steps;
                    timer_clr = 1'b1;
                    state_nxt = ST_MOVE;
                end
            end
            ST_MOVE: begin
                if (turn_end) pend_nxt = 1'b1;
                if (step_tick && steps_q != 2'd0) begin
                    for (int k = 0; k < NUM_PLAYERS; k++) begin
                        if (player_t'(k) == cur_q) pos_nxt[k] = pos_inc;
                    end
                    if (pos_inc == FINISH) begin
                        // Reaching the finish ends the move; leftover steps are discarded.
                        steps_nxt = 2'd0;
                        go_nxt    = 1'b1;
                        win_nxt   = cur_q;
                        state_nxt = ST_WIN;
                    end else begin
                        steps_nxt = steps_q - 2'd1;
                        if (steps_q == 2'd1) begin
                            if (pend_q || turn_end) begin
                                cur_nxt   = next_player;
                                pend_nxt  = 1'b0;
                                state_nxt = ST_WAIT_ROLL;
                            end else begin
                                state_nxt = ST_WAIT_CLEAR;
                            end
                        end
                    end
                end
            end
            ST_WAIT_CLEAR: begin
                if (turn_end) begin
                    cur_nxt   = next_player;
                    state_nxt = ST_WAIT_ROLL;
                end
            end
            ST_WIN: ;
            default: state_nxt = ST_IDLE;
        endcase

        if (new_game) begin
            pos_nxt   = '0;
            cur_nxt   = '0;
            steps_nxt = '0;
            go_nxt    = 1'b0;
            win_nxt   = '0;
            pend_nxt  = 1'b0;
            timer_clr = 1'b1;
            state_nxt = ST_WAIT_ROLL;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            pos_q   <= '0;
            steps_q <= '0;
            go_q    <= 1'b0;
            win_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cur_q   <= cur_nxt;
            pos_q   <= pos_nxt;
            steps_q <= steps_nxt;
            go_q    <= go_nxt;
            win_q   <= win_nxt;
            pend_q  <= pend_nxt;
        end
    end

    assign cur_player = cur_q;
    assign player_pos = pos_q;
    assign steps_left = steps_q;
    assign moving     = (state_q == ST_MOVE);
    assign game_over  = go_q;
    assign winner     = win_q;
    assign fsm_state  = state_q;

endmodule

// File: tb/tb_dice_race_turn_fsm.sv
// Bench for dice_race_turn_fsm with STEP_CYCLES=4, BOARD_LEN=8, NUM_PLAYERS=2.
module tb_dice_race_turn_fsm;

    localparam int STEP = 4;
    localparam logic [2:0] S_IDLE = 3'd0, S_ROLL = 3'd1, S_MOVE = 3'd2, S_CLEAR = 3'd3, S_WIN = 3'd4;

    logic       clk = 1'b0;
    logic       reset, new_game, result_ready, turn_end;
    logic [1:0] movement_steps;
    logic [1:0] cur_player, steps_left, winner;
    logic [9:0] player_pos;
    logic       moving, game_over;
    logic [2:0] fsm_state;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int t_ref = 0;

    logic [4:0] mpos [2];
    int         mcur;
    logic [9:0] sb [$];

    dice_race_turn_fsm #(
        .NUM_PLAYERS(2), .BOARD_LEN(8), .POS_W(5), .STEP_CYCLES(STEP)
    ) dut (
        .clk(clk), .reset(reset), .new_game(new_game), .result_ready(result_ready),
        .movement_steps(movement_steps), .turn_end(turn_end), .cur_player(cur_player),
        .player_pos(player_pos), .steps_left(steps_left), .moving(moving),
        .game_over(game_over), .winner(winner), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [9:0] pack_pos();
        return {mpos[1], mpos[0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit ng, input bit rr, input logic [1:0] ms, input bit te);
        new_game = ng; result_ready = rr; movement_steps = ms; turn_end = te;
        tick();
        new_game = 0; result_ready = 0; movement_steps = 0; turn_end = 0;
    endtask

    task automatic model_clear();
        mpos[0] = 0; mpos[1] = 0; mcur = 0;
    endtask

    task automatic check_state(input logic [2:0] st, input string tag);
        checks++;
        if (fsm_state !== st) begin errs++; $display("FAIL %s state: got %0d want %0d", tag, fsm_state, st); end
        checks++;
        if (cur_player !== 2'(mcur)) begin errs++; $display("FAIL %s cur_player: got %0d want %0d", tag, cur_player, mcur); end
        checks++;
        if (player_pos !== pack_pos()) begin errs++; $display("FAIL %s pos: got %h want %h", tag, player_pos, pack_pos()); end
    endtask

    // mid: 0 none, 1 turn_end during move, 2 result_ready during move, 3 turn_end with the roll
    task automatic do_roll(input int steps, input int mid, input string tag);
        logic [9:0] prev, e;
        int n, waited;
        bit won;
        n = 0; won = 0;
        for (int i = 0; i < steps; i++) begin
            mpos[mcur] = mpos[mcur] + 1;
            sb.push_back(pack_pos());
            n++;
            if (mpos[mcur] == 5'd7) begin won = 1; break; end
        end
        prev = player_pos;
        pulse(0, 1, 2'(steps), mid == 3);
        t_ref = cyc;
        checks++;
        if (steps_left !== 2'(steps) || moving !== 1'b1) begin
            errs++; $display("FAIL %s accept: steps_left=%0d moving=%b want %0d/1", tag, steps_left, moving, steps);
        end
        if (mid == 1) pulse(0, 0, 0, 1);
        else if (mid == 2) pulse(0, 1, 2'd3, 0);
        for (int k = 1; k <= n; k++) begin
            e = sb.pop_front();
            waited = 0;
            while (player_pos === prev && waited < 3 * STEP) begin
                checks++;
                if (moving !== 1'b1) begin errs++; $display("FAIL %s moving: got %b want 1", tag, moving); end
                tick();
                waited++;
            end
            checks++;
            if (player_pos === prev) begin
                errs++; $display("FAIL %s advance %0d timeout: pos %h want %h", tag, k, player_pos, e);
            end else begin
                checks++;
                if (player_pos !== e) begin errs++; $display("FAIL %s advance %0d pos: got %h want %h", tag, k, player_pos, e); end
                if (cyc - t_ref != STEP * k) begin errs++; $display("FAIL %s advance %0d time: got %0d want %0d", tag, k, cyc - t_ref, STEP * k); end
            end
            prev = player_pos;
        end
        if (won) begin
            check_state(S_WIN, tag);
        end else if (mid == 1) begin
            mcur = (mcur == 1) ? 0 : 1;
            check_state(S_ROLL, tag);
        end else begin
            check_state(S_CLEAR, tag);
        end
        checks++;
        if (moving !== 1'b0 || steps_left !== 2'd0) begin
            errs++; $display("FAIL %s end: moving=%b steps_left=%0d want 0/0", tag, moving, steps_left);
        end
    endtask

    task automatic end_turn(input string tag);
        pulse(0, 0, 0, 1);
        mcur = (mcur == 1) ? 0 : 1;
        check_state(S_ROLL, tag);
    endtask

    task automatic check_reset_vals(input string tag);
        checks++;
        if (fsm_state !== S_IDLE || cur_player !== 0 || player_pos !== 0 || steps_left !== 0 ||
            moving !== 0 || game_over !== 0 || winner !== 0) begin
            errs++;
            $display("FAIL %s: st=%0d cur=%0d pos=%h steps=%0d mov=%b go=%b win=%0d want all 0",
                     tag, fsm_state, cur_player, player_pos, steps_left, moving, game_over, winner);
        end
    endtask

    task automatic test_reset();
        reset = 0; new_game = 0; result_ready = 0; turn_end = 0; movement_steps = 0;
        model_clear();
        repeat (2) tick();
        check_reset_vals("reset");
        reset = 1;
        tick();
        pulse(0, 1, 2'd3, 1);
        check_reset_vals("idle_ignores");
    endtask

    task automatic test_first_move();
        pulse(1, 0, 0, 0);
        model_clear();
        check_state(S_ROLL, "new_game");
        do_roll(3, 0, "p0_roll3");
        pulse(0, 1, 2'd2, 0);
        check_state(S_CLEAR, "rr_in_clear");
        end_turn("p0_end");
    endtask

    task automatic test_ignored_inputs();
        pulse(0, 1, 2'd0, 0);
        check_state(S_ROLL, "roll_zero");
        checks++;
        if (moving !== 0 || steps_left !== 0) begin errs++; $display("FAIL roll_zero: moving=%b steps=%0d want 0/0", moving, steps_left); end
        pulse(0, 0, 0, 1);
        check_state(S_ROLL, "te_in_roll");
        do_roll(1, 2, "p1_rr_mid");
        end_turn("p1_wrap");
    endtask

    task automatic test_pending_end();
        do_roll(2, 1, "p0_pending");
    endtask

    task automatic test_back_to_back();
        do_roll(3, 0, "p1_roll3");
        end_turn("p1_end2");
        do_roll(1, 3, "p0_rr_te_same");
        end_turn("p0_end2");
        do_roll(1, 0, "p1_roll1");
        end_turn("p1_end3");
    endtask

    task automatic test_win();
        do_roll(3, 0, "p0_win");
        checks++;
        if (game_over !== 1'b1 || winner !== 2'd0) begin errs++; $display("FAIL win flags: go=%b winner=%0d want 1/0", game_over, winner); end
        repeat (3 * STEP) tick();
        check_state(S_WIN, "win_hold");
        pulse(0, 1, 2'd3, 0);
        pulse(0, 0, 0, 1);
        check_state(S_WIN, "win_ignores");
        checks++;
        if (game_over !== 1'b1 || winner !== 2'd0) begin errs++; $display("FAIL win stable: go=%b winner=%0d want 1/0", game_over, winner); end
        pulse(1, 0, 0, 0);
        model_clear();
        check_state(S_ROLL, "restart");
        checks++;
        if (game_over !== 1'b0) begin errs++; $display("FAIL restart go: got %b want 0", game_over); end
    endtask

    task automatic test_reset_mid_move();
        pulse(0, 1, 2'd3, 0);
        repeat (STEP + 1) tick();
        checks++;
        if (player_pos !== 10'd1 || moving !== 1'b1) begin errs++; $display("FAIL pre_reset: pos=%h mov=%b want 001/1", player_pos, moving); end
        reset = 0;
        #1;
        check_reset_vals("async_reset");
        #2;
        reset = 1;
        repeat (STEP + 2) tick();
        check_reset_vals("after_release");
    endtask

    initial begin
        test_reset();
        test_first_move();
        test_ignored_inputs();
        test_pending_end();
        test_back_to_back();
        test_win();
        test_reset_mid_move();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
